aes_text_out_stage: RTL and testbench
=====================================

Name: aes_text_out_stage

Overview:
- Output stage of aes_cipher_top, directly upstream of the output buffers (output*.A) that drive the text_out pins.
- Applies the final AddRoundKey (state XOR last round key) to the cipher core's last-round result and registers it into the 128-bit text_out register.
- Holds results behind a 2-entry valid/ready skid buffer so the core can finish a block while the consumer stalls.
- Counts delivered blocks for debug and coverage.

Parameters:
- DATA_W, 128, block width in bits; multiple of 8.
- BYTE_SWAP, 0, when 1, byte order is reversed on capture (byte 0 ↔ byte DATA_W/8-1).
- CNT_W, 16, width of the delivered-block counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the core presents the final-round state.
- in_ready  out  1  the stage can accept a block.
- in_state  in  DATA_W  last-round state after SubBytes and ShiftRows.
- in_key  in  DATA_W  last round key.
- out_valid  out  1  text_out holds an undelivered block.
- out_ready  in  1  the consumer accepts text_out.
- text_out  out  DATA_W  ciphertext, driven directly from the head register.
- blk_cnt  out  CNT_W  number of blocks delivered (pops); wraps.

Behaviour:
- Reset (rst=1 at a clock edge):
  - text_out=0, out_valid=0, blk_cnt=0, skid register=0, FSM=EMPTY.
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after rst falls.
- Push and pop:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Captured value d = in_state ^ in_key, byte-reversed first if BYTE_SWAP=1.
- Latency: one cycle from push to out_valid=1 when FSM=EMPTY. There is no combinational path from in_* to text_out.
- in_ready = !rst & (FSM != FULL). This depends only on registered state, with no combinational dependency on out_ready.
- FSM states: EMPTY (0 entries), ONE (head valid), FULL (head and skid valid).
  - EMPTY & push → ONE; head ← d.
  - ONE & push & !pop → FULL; skid ← d.
  - ONE & push & pop → ONE; head ← d.
  - ONE & !push & pop → EMPTY.
  - FULL & pop → ONE; head ← skid. A push cannot occur in FULL because in_ready=0.
  - In every other case the state and registers hold.
- out_valid = (FSM != EMPTY), registered.
- text_out holds its last value in EMPTY and is never cleared except by rst, so the head flops stay stable for equivalence checking.
- blk_cnt increments by 1 on every pop, modulo 2^CNT_W; it wraps from all-ones to 0 with no flag.
- Reset mid-operation: any buffered blocks are discarded and there is no pop. blk_cnt is not incremented even if out_ready was high in the reset cycle.
- in_valid while in_ready=0: ignored. The core must hold in_state and in_key stable until it sees the push.
- X handling: in_state and in_key are sampled only on push.

Decomposition:
- Shared package aes_pkg:
  - AES_BLK_W=128.
  - typedef aes_blk_t (logic [127:0]).
  - enum out_fsm_e {EMPTY, ONE, FULL}.
  - function byte_rev(aes_blk_t).
- One sub-module: aes_skid2, a generic 2-entry valid/ready skid buffer parameterized by width. aes_text_out_stage instantiates it and adds the XOR, the byte-swap and the counter.

Test Plan:
- Single block, no stall: in_state=0, in_key=128'h69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 → one cycle later out_valid=1 and text_out=69c4…c55a; blk_cnt=1 after the pop; FSM returns to EMPTY and text_out stays unchanged.
- XOR and byte-swap: in_state=128'h000102…0f, in_key=128'hff…ff.
  - BYTE_SWAP=0 → text_out=128'hfffefd…f0.
  - BYTE_SWAP=1 → text_out=128'hf0f1…ff.
- Backpressure fill: hold out_ready=0 and push A=1, then B=2 on consecutive cycles → in_ready drops the cycle after B is accepted; a third in_valid is ignored; text_out=1.
- Drain: raise out_ready → the first pop delivers 1, then 2, on consecutive cycles; blk_cnt goes to 2; in_ready=1 again the cycle after the first pop.
- Simultaneous push and pop in ONE: head=A, push C with out_ready=1 → next cycle text_out=C, FSM=ONE, out_valid stays 1, blk_cnt+1.
- Reset and wrap:
  - Assert rst while FULL with out_ready=1 → out_valid=0, text_out=0, blk_cnt unchanged at 0 after reset, in_ready=0 during reset.
  - With CNT_W=4, 16 pops → blk_cnt=0.

Source files
------------

// File: rtl/aes_pkg.sv
// +-----------------------------------------------------------------+
// | aes_pkg: shared AES block type, output FSM encoding, byte_rev    |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

package aes_pkg;

  localparam int AES_BLK_W = 128;

  typedef logic [AES_BLK_W-1:0] aes_blk_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } out_fsm_e;

  function automatic aes_blk_t byte_rev(input aes_blk_t x);
    aes_blk_t r;
    for (int i = 0; i < AES_BLK_W / 8; i++) begin
      r[8*i +: 8] = x[AES_BLK_W-8-8*i +: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_skid2.sv
// +-----------------------------------------------------------------+
// | aes_skid2: 2-entry valid/ready skid buffer, registered outputs   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module aes_skid2
  import aes_pkg::*;
#(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  out_fsm_e     r_state;
  logic [W-1:0] r_head;
  logic [W-1:0] r_skid;
  logic         r_valid;
  logic         w_push;
  logic         w_pop;

  // Ready looks only at registered state so no out_ready->in_ready path exists.
  assign o_ready = !rst && (r_state != FULL);
  assign w_push  = i_valid && o_ready;
  assign w_pop   = r_valid && i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_head  <= i_data;
            r_state <= ONE;
            r_valid <= 1'b1;
          end
        end
        ONE: begin
          if (w_push && !w_pop) begin
            r_skid  <= i_data;
            r_state <= FULL;
          end else if (w_push && w_pop) begin
            r_head <= i_data;
          end else if (w_pop) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
          end
        end
        FULL: begin
          if (w_pop) begin
            r_head  <= r_skid;
            r_state <= ONE;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/aes_text_out_stage.sv
// +-----------------------------------------------------------------+
// | aes_text_out_stage: final AddRoundKey, optional byte swap, skid  |
// | buffered text_out register and delivered-block counter. Rev 1.0  |
// +-----------------------------------------------------------------+
`default_nettype none

module aes_text_out_stage
  import aes_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int BYTE_SWAP = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_state,
  input  logic [DATA_W-1:0] in_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] text_out,
  output logic [CNT_W-1:0]  blk_cnt
);

  logic [DATA_W-1:0] w_x;
  logic [DATA_W-1:0] w_d;
  logic [CNT_W-1:0]  r_cnt;

  assign w_x = in_state ^ in_key;

  generate
    if (BYTE_SWAP != 0 && DATA_W == AES_BLK_W) begin : g_rev_pkg
      assign w_d = byte_rev(w_x);
    end else if (BYTE_SWAP != 0) begin : g_rev_loop
      for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_byte
        assign w_d[8*gi +: 8] = w_x[DATA_W-8-8*gi +: 8];
      end
    end else begin : g_norev
      assign w_d = w_x;
    end
  endgenerate

  aes_skid2 #(
    .W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_d),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (text_out)
  );

  // Reset has priority, so a pop seen in the reset cycle is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (out_valid && out_ready) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign blk_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_aes_text_out_stage.sv
// Directed bench: two DUT instances (plain/16-bit count, swapped/4-bit count)
// checked every cycle against a queue model plus literal expectations.
`default_nettype none

module tb_aes_text_out_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_state = '0;
  logic [127:0] in_key = '0;

  logic         in_ready0, out_valid0, in_ready1, out_valid1;
  logic [127:0] text0, text1;
  logic [15:0]  cnt0;
  logic [3:0]   cnt1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  localparam logic [127:0] K1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 clk = ~clk;

  aes_text_out_stage #(.DATA_W(128), .BYTE_SWAP(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_state(in_state), .in_key(in_key), .out_valid(out_valid0),
    .out_ready(out_ready), .text_out(text0), .blk_cnt(cnt0)
  );

  aes_text_out_stage #(.DATA_W(128), .BYTE_SWAP(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_state(in_state), .in_key(in_key), .out_valid(out_valid1),
    .out_ready(out_ready), .text_out(text1), .blk_cnt(cnt1)
  );

  function automatic logic [127:0] rev(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a FIFO of at most two captured blocks; head is what text_out shows.
  logic [127:0] q[$];
  logic [127:0] m_head = '0;
  int           m_cnt = 0;

  initial begin
    bit pop, push;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_head = '0;
        m_cnt  = 0;
      end else begin
        pop  = (q.size() > 0) && out_ready;
        push = in_valid && (q.size() < 2);
        if (pop) begin
          void'(q.pop_front());
          m_cnt++;
        end
        if (push) q.push_back(in_state ^ in_key);
        if (q.size() > 0) m_head = q[0];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready0",  {127'd0, in_ready0},  {127'd0, !rst && q.size() < 2});
      chk("in_ready1",  {127'd0, in_ready1},  {127'd0, !rst && q.size() < 2});
      chk("out_valid0", {127'd0, out_valid0}, {127'd0, q.size() > 0});
      chk("out_valid1", {127'd0, out_valid1}, {127'd0, q.size() > 0});
      chk("text0", text0, m_head);
      chk("text1", text1, rev(m_head));
      chk("cnt0", {112'd0, cnt0}, 128'(m_cnt % 65536));
      chk("cnt1", {124'd0, cnt1}, 128'(m_cnt % 16));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [127:0] s, input logic [127:0] k, input logic r);
    in_valid  = v;
    in_state  = s;
    in_key    = k;
    out_ready = r;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_in_ready", {127'd0, in_ready0}, 128'd0);
    chk("rst_text", text0, 128'd0);
    chk("rst_cnt", {112'd0, cnt0}, 128'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", {127'd0, in_ready0}, 128'd1);

    // Single block, no stall
    drive(1'b1, 128'd0, K1, 1'b1);
    tick();
    chk("single_valid", {127'd0, out_valid0}, 128'd1);
    chk("single_text", text0, K1);
    drive(1'b0, 128'd0, 128'd0, 1'b1);
    tick();
    chk("single_cnt", {112'd0, cnt0}, 128'd1);
    chk("single_empty", {127'd0, out_valid0}, 128'd0);
    chk("single_hold", text0, K1);

    // XOR and byte swap
    drive(1'b1, 128'h000102030405060708090a0b0c0d0e0f, {128{1'b1}}, 1'b0);
    tick();
    drive(1'b0, 128'd0, 128'd0, 1'b0);
    chk("xor_noswap", text0, 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0);
    chk("xor_swap", text1, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
    out_ready = 1'b1;
    tick();

    // Backpressure fill from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    drive(1'b1, 128'd1, 128'd0, 1'b0);
    tick();
    drive(1'b1, 128'd2, 128'd0, 1'b0);
    tick();
    chk("full_in_ready", {127'd0, in_ready0}, 128'd0);
    drive(1'b1, 128'd3, 128'd0, 1'b0);
    tick();
    chk("full_text", text0, 128'd1);
    chk("full_ignore_ready", {127'd0, in_ready0}, 128'd0);

    // Drain
    drive(1'b0, 128'd0, 128'd0, 1'b1);
    tick();
    chk("drain1_text", text0, 128'd2);
    chk("drain1_ready", {127'd0, in_ready0}, 128'd1);
    chk("drain1_cnt", {112'd0, cnt0}, 128'd1);
    tick();
    chk("drain2_cnt", {112'd0, cnt0}, 128'd2);
    chk("drain2_empty", {127'd0, out_valid0}, 128'd0);

    // Simultaneous push and pop in ONE
    drive(1'b1, 128'd5, 128'd0, 1'b0);
    tick();
    drive(1'b1, 128'd6, 128'd0, 1'b1);
    tick();
    chk("pp_text", text0, 128'd6);
    chk("pp_valid", {127'd0, out_valid0}, 128'd1);
    chk("pp_cnt", {112'd0, cnt0}, 128'd3);
    drive(1'b0, 128'd0, 128'd0, 1'b1);
    tick();

    // Reset while FULL with out_ready high
    drive(1'b1, 128'd7, 128'd0, 1'b0);
    tick();
    drive(1'b1, 128'd8, 128'd0, 1'b0);
    tick();
    drive(1'b0, 128'd0, 128'd0, 1'b1);
    rst = 1'b1;
    chk("rst_full_ready", {127'd0, in_ready0}, 128'd0);
    tick();
    chk("rst_full_valid", {127'd0, out_valid0}, 128'd0);
    chk("rst_full_text", text0, 128'd0);
    chk("rst_full_cnt", {112'd0, cnt0}, 128'd0);
    rst = 1'b0;
    tick();

    // Counter wrap: 16 pops
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 128'(i + 16), 128'h0f, 1'b1);
      tick();
    end
    drive(1'b0, 128'd0, 128'd0, 1'b1);
    tick();
    chk("wrap_cnt4", {124'd0, cnt1}, 128'd0);
    chk("wrap_cnt16", {112'd0, cnt0}, 128'd16);
    chk("wrap_text", text0, 128'h10);
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
